// File: rtl/loader_pkg.sv
// Shared constants for the boot-time SPI-flash loader.
// Macro LOADER_FASTREAD_EN (see flash_loader) selects the fast-read command.
package loader_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_FAST = 8'h0B;
  localparam logic [7:0] DUMMY    = 8'hFF;

  localparam int XFER_TICKS = 17;
  localparam int TW         = 5;

  localparam logic [2:0] S_GUARD = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  // Byte sent on command transfer idx: opcode, then address MSB first.
  function automatic logic [7:0] cmd_byte(
    input logic [7:0]  op,
    input logic [23:0] a,
    input logic [2:0]  idx
  );
    case (idx)
      3'd0:    return op;
      3'd1:    return a[23:16];
      3'd2:    return a[15:8];
      3'd3:    return a[7:0];
      default: return DUMMY;
    endcase
  endfunction

endpackage

// File: rtl/spi_pacer.sv
// Counts ce ticks after each shifter request; o_ready when the shifter is free.
// Ports: i_clock, i_reset_n, i_ce, i_load (request issued), o_ready.
module spi_pacer
  import loader_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_ce,
  input  logic i_load,
  output logic o_ready
);

  logic [TW-1:0] r_cnt;

  // Reset loads one tick more than a request does: the shifter has no
  // reset and may be mid-byte, so a full byte time must pass first.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= TW'(XFER_TICKS);
    end else if (i_ce) begin
      if (i_load)
        r_cnt <= TW'(XFER_TICKS - 1);
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_ready = (r_cnt == '0);

endmodule

// File: rtl/flash_loader.sv
// SPI-flash READ loader: streams len bytes from flash[base] into memory.
// Ports: clock/reset(n)/ce, start/base/len/busy/done, cs, spi_io/d/q, mem_*.
// Macro LOADER_FASTREAD_EN: use 0Bh plus one dummy byte instead of 03h.
module flash_loader
  import loader_pkg::*;
#(
  parameter int MW = 19
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          start,
  input  logic [23:0]   base,
  input  logic [MW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          cs,
  output logic          spi_io,
  output logic [7:0]    spi_d,
  input  logic [7:0]    spi_q,
  output logic [MW-1:0] mem_a,
  output logic [7:0]    mem_d,
  output logic          mem_wr,
  input  logic          mem_ack
);

`ifdef LOADER_FASTREAD_EN
  localparam logic [7:0] CMD_BYTE = CMD_FAST;
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [7:0] CMD_BYTE = CMD_READ;
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  logic [2:0]    r_state;
  logic [2:0]    r_idx;
  logic [23:0]   r_base;
  logic [MW:0]   r_len;
  logic [MW:0]   r_rem;
  logic          r_first;
  logic          r_flushed;
  logic          r_pend;
  logic          r_cs;
  logic          r_wr;
  logic [MW-1:0] r_a;
  logic [7:0]    r_d;

  logic          w_rdy;
  logic          w_want;
  logic          w_io;
  logic [7:0]    w_d;

  spi_pacer u_pacer (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_ce      (ce),
    .i_load    (w_io),
    .o_ready   (w_rdy)
  );

  always_comb begin
    w_want = 1'b0;
    unique case (1'b1)
      r_state == S_CMD:   w_want = 1'b1;
      r_state == S_DATA:  w_want = 1'b1;
      r_state == S_FLUSH: w_want = !r_flushed;
      default:            w_want = 1'b0;
    endcase
  end

  // A byte still waiting to be captured or written holds the SPI clock.
  assign w_io = ce & w_rdy & w_want & ~r_wr & ~r_pend;

  always_comb begin
    w_d = DUMMY;
    if (r_state == S_CMD)
      w_d = cmd_byte(CMD_BYTE, r_base, r_idx);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_GUARD;
      r_idx     <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_rem     <= '0;
      r_first   <= 1'b0;
      r_flushed <= 1'b0;
      r_pend    <= 1'b0;
      r_cs      <= 1'b1;
      r_wr      <= 1'b0;
      r_a       <= '0;
      r_d       <= '0;
    end else begin
      if (r_wr && mem_ack) begin
        r_wr <= 1'b0;
        r_a  <= r_a + 1'b1;
      end
      // spi_q now holds the rx byte of the transfer before the last io.
      if (ce && r_pend) begin
        r_d    <= spi_q;
        r_wr   <= 1'b1;
        r_pend <= 1'b0;
      end
      case (r_state)
        S_GUARD: begin
          if (w_rdy)
            r_state <= S_IDLE;
        end
        S_IDLE, S_END: begin
          r_state <= S_IDLE;
          if (start && ce) begin
            r_base    <= base;
            r_len     <= len;
            r_rem     <= len;
            r_idx     <= '0;
            r_a       <= '0;
            r_flushed <= 1'b0;
            r_cs      <= 1'b0;
            r_state   <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_io) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
              r_first <= 1'b1;
              r_state <= (r_len != '0) ? S_DATA : S_FLUSH;
            end
          end
        end
        S_DATA: begin
          if (w_io) begin
            // First data io returns command-phase junk.
            r_first <= 1'b0;
            r_pend  <= ~r_first;
            r_rem   <= r_rem - 1'b1;
            if (r_rem == {{MW{1'b0}}, 1'b1})
              r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_io) begin
            r_flushed <= 1'b1;
            r_pend    <= (r_len != '0);
          end else if (r_flushed && w_rdy && !r_pend && !r_wr) begin
            r_cs    <= 1'b1;
            r_state <= S_END;
          end
        end
        default: r_state <= S_GUARD;
      endcase
    end
  end

  assign busy   = !(r_state == S_IDLE || r_state == S_END);
  assign done   = (r_state == S_END);
  assign cs     = r_cs;
  assign spi_io = w_io;
  assign spi_d  = w_d;
  assign mem_a  = r_a;
  assign mem_d  = r_d;
  assign mem_wr = r_wr;

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader with a behavioural SPI shifter, flash and memory.
// Expected traffic is derived from the READ protocol, not from the RTL.
module tb_flash_loader;

  localparam int MW = 19;
`ifdef LOADER_FASTREAD_EN
  localparam int HDR = 5;
  localparam logic [7:0] CMDB = 8'h0B;
`else
  localparam int HDR = 4;
  localparam logic [7:0] CMDB = 8'h03;
`endif

  logic          clock;
  logic          rst_n;
  logic          ce;
  logic          start;
  logic [23:0]   base;
  logic [MW:0]   len;
  logic          busy;
  logic          done;
  logic          cs;
  logic          spi_io;
  logic [7:0]    spi_d;
  logic [7:0]    spi_q = 8'h00;
  logic [MW-1:0] mem_a;
  logic [7:0]    mem_d;
  logic          mem_wr;
  logic          mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  int         ack_dly = 0;
  bit         spur = 0;
  logic [7:0] fseed = 8'h00;

  flash_loader #(.MW(MW)) dut (
    .clock   (clock),
    .reset   (rst_n),
    .ce      (ce),
    .start   (start),
    .base    (base),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .cs      (cs),
    .spi_io  (spi_io),
    .spi_d   (spi_d),
    .spi_q   (spi_q),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_wr  (mem_wr),
    .mem_ack (mem_ack)
  );

  // ce every second clock, changed just after the rising edge.
  initial begin
    clock = 1'b0;
    ce = 1'b0;
    forever begin
      #5 clock = 1'b1;
      #1 ce = ~ce;
      #4 clock = 1'b0;
    end
  end

  function automatic logic [7:0] flash_byte(
    input logic [23:0] a,
    input logic [7:0]  s
  );
    logic [31:0] h;
    h = {8'h00, a} * 32'h9E3779B1;
    return h[23:16] ^ s;
  endfunction

  // Shifter + flash: q at each io = rx byte of the previous transfer.
  logic [7:0]  prev_rx = 8'h00;
  int          gap = 16;
  int          sidx = 0;
  logic [23:0] saddr = 24'h0;
  int          pace_bad = 0;
  logic [7:0]  mosi[$];

  always @(posedge clock) begin
    if (cs)
      sidx <= 0;
    if (spi_io && !ce)
      pace_bad <= pace_bad + 1;
    if (ce && spi_io) begin
      if (gap < 16)
        pace_bad <= pace_bad + 1;
      gap <= 0;
      mosi.push_back(spi_d);
      spi_q <= prev_rx;
      if (sidx >= HDR)
        prev_rx <= flash_byte(24'(saddr + 24'(sidx - HDR)), fseed);
      else
        prev_rx <= 8'hC3 ^ 8'(sidx);
      if (sidx >= 1 && sidx <= 3)
        saddr <= {saddr[15:0], spi_d};
      sidx <= sidx + 1;
    end else if (ce) begin
      gap <= gap + 1;
    end
  end

  // Memory: ack after ack_dly clocks, optional stray acks when idle.
  logic [MW+7:0] wq[$];
  int            wcnt = 0;
  bit            hold = 0;
  logic [MW-1:0] ha;
  logic [7:0]    hd;
  int            stab_bad = 0;

  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (mem_wr) begin
      if (!hold) begin
        ha = mem_a;
        hd = mem_d;
        hold = 1;
      end else if (mem_a !== ha || mem_d !== hd) begin
        stab_bad++;
      end
      if (wcnt >= ack_dly) begin
        mem_ack = 1'b1;
        wq.push_back({mem_a, mem_d});
      end else begin
        wcnt++;
      end
    end else begin
      hold = 0;
      wcnt = 0;
      if (spur && $urandom_range(0, 3) == 0)
        mem_ack = 1'b1;
    end
  end

  task automatic guard_ticks(input int hold_n, output int ticks,
                             output bit bad);
    ticks = 0;
    bad = 0;
    while (busy && ticks < 100) begin
      start = (ticks < hold_n);
      base = 24'($urandom);
      if (cs !== 1'b1)
        bad = 1;
      if (ce)
        ticks++;
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic run_load(input string nm, input logic [23:0] b,
                          input int n, input int dly, input bit spam);
    int m0, w0, p0, s0, t, dn;
    logic [7:0]    exp_m[$];
    logic [7:0]    got;
    logic [MW+7:0] gw, ew;
    m0 = mosi.size();
    w0 = wq.size();
    p0 = pace_bad;
    s0 = stab_bad;
    ack_dly = dly;
    exp_m.push_back(CMDB);
    exp_m.push_back(b[23:16]);
    exp_m.push_back(b[15:8]);
    exp_m.push_back(b[7:0]);
    if (HDR == 5)
      exp_m.push_back(8'hFF);
    for (int i = 0; i <= n; i++)
      exp_m.push_back(8'hFF);
    @(negedge clock);
    base = b;
    len = (MW+1)'(n);
    start = 1'b1;
    t = 0;
    while (!busy && t < 200) begin
      @(negedge clock);
      t++;
    end
    start = 1'b0;
    base = 24'($urandom);
    len = (MW+1)'($urandom);
    checks++;
    if (busy !== 1'b1 || cs !== 1'b0) begin
      errors++;
      $display("FAIL %s accept busy=%b cs=%b want 1 0", nm, busy, cs);
    end
    t = 0;
    dn = 0;
    while (t < 20000) begin
      @(negedge clock);
      t++;
      if (done)
        dn++;
      if (spam) begin
        start = ((wq.size() - w0) < n - 1) ? 1'($urandom) : 1'b0;
        base = 24'($urandom);
        len = (MW+1)'($urandom_range(0, 7));
      end
      if (!busy)
        break;
    end
    start = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (done)
        dn++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout busy=%b want 0", nm, busy);
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL %s done pulses got %0d want 1", nm, dn);
    end
    checks++;
    if (cs !== 1'b1) begin
      errors++;
      $display("FAIL %s cs after got %b want 1", nm, cs);
    end
    checks++;
    if (mosi.size() - m0 !== exp_m.size()) begin
      errors++;
      $display("FAIL %s xfer count got %0d want %0d", nm,
               mosi.size() - m0, exp_m.size());
    end
    for (int i = 0; i < exp_m.size(); i++) begin
      got = (m0 + i < mosi.size()) ? mosi[m0 + i] : 8'hxx;
      checks++;
      if (got !== exp_m[i]) begin
        errors++;
        $display("FAIL %s mosi[%0d] got %h want %h", nm, i, got, exp_m[i]);
      end
    end
    checks++;
    if (wq.size() - w0 !== n) begin
      errors++;
      $display("FAIL %s write count got %0d want %0d", nm,
               wq.size() - w0, n);
    end
    for (int i = 0; i < n; i++) begin
      gw = (w0 + i < wq.size()) ? wq[w0 + i] : 'x;
      ew = {MW'(i), flash_byte(24'(b + 24'(i)), fseed)};
      checks++;
      if (gw !== ew) begin
        errors++;
        $display("FAIL %s write[%0d] got a=%h d=%h want a=%h d=%h", nm, i,
                 gw[MW+7:8], gw[7:0], ew[MW+7:8], ew[7:0]);
      end
    end
    checks++;
    if (pace_bad - p0 !== 0) begin
      errors++;
      $display("FAIL %s io pacing violations got %0d want 0", nm,
               pace_bad - p0);
    end
    checks++;
    if (stab_bad - s0 !== 0) begin
      errors++;
      $display("FAIL %s mem hold changes got %0d want 0", nm,
               stab_bad - s0);
    end
  endtask

  task automatic test_reset;
    int  tk;
    bit  bad;
    rst_n = 1'b0;
    start = 1'b0;
    base = '0;
    len = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, cs, spi_io} !== 4'b1010) begin
      errors++;
      $display("FAIL reset flags busy/done/cs/io got %b want 1010",
               {busy, done, cs, spi_io});
    end
    checks++;
    if (spi_d !== 8'hFF) begin
      errors++;
      $display("FAIL reset spi_d got %h want ff", spi_d);
    end
    checks++;
    if ({mem_wr, mem_a, mem_d} !== '0) begin
      errors++;
      $display("FAIL reset mem got wr=%b a=%h d=%h want 0", mem_wr,
               mem_a, mem_d);
    end
    rst_n = 1'b1;
    guard_ticks(0, tk, bad);
    checks++;
    if (tk < 17 || tk > 18) begin
      errors++;
      $display("FAIL reset guard ticks got %0d want 17..18", tk);
    end
  endtask

  task automatic test_basic;
    fseed = 8'($urandom);
    run_load("basic", 24'h012345, 4, 0, 0);
  endtask

  task automatic test_len0;
    run_load("len0", 24'($urandom), 0, 0, 0);
  endtask

  task automatic test_slow_ack;
    run_load("slow_ack", 24'($urandom), 3, 40, 0);
  endtask

  task automatic test_busy_start;
    run_load("busy_start", 24'($urandom), 4, 2, 1);
  endtask

  task automatic test_wrap;
    run_load("wrap", 24'hFFFFFE, 4, 1, 0);
  endtask

  task automatic test_random;
    spur = 1;
    for (int k = 0; k < 4; k++) begin
      fseed = 8'($urandom);
      run_load("random", 24'($urandom), $urandom_range(1, 6),
               $urandom_range(0, 5), 0);
    end
    spur = 0;
  endtask

  task automatic test_back_to_back;
    run_load("b2b_a", 24'($urandom), 2, 0, 0);
    run_load("b2b_b", 24'($urandom), 3, 0, 0);
  endtask

  task automatic test_reset_mid;
    int w0, t, tk;
    bit bad;
    w0 = wq.size();
    ack_dly = 3;
    @(negedge clock);
    base = 24'($urandom);
    len = (MW+1)'(6);
    start = 1'b1;
    t = 0;
    while (!busy && t < 200) begin
      @(negedge clock);
      t++;
    end
    start = 1'b0;
    t = 0;
    while ((wq.size() - w0) < 2 && t < 5000) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (wq.size() - w0 < 2) begin
      errors++;
      $display("FAIL reset_mid writes before reset got %0d want 2",
               wq.size() - w0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs, busy, done, mem_wr, spi_io} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_mid cs/busy/done/wr/io got %b want 11000",
               {cs, busy, done, mem_wr, spi_io});
    end
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    guard_ticks(10, tk, bad);
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid start in guard got cs low want high");
    end
    checks++;
    if (tk < 17 || tk > 18) begin
      errors++;
      $display("FAIL reset_mid guard ticks got %0d want 17..18", tk);
    end
    fseed = 8'($urandom);
    run_load("rerun", 24'($urandom), 5, 1, 0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_len0;
    test_slow_ack;
    test_busy_start;
    test_wrap;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
